simd_shifter_pipe: RTL and testbench
====================================

Name: simd_shifter_pipe

Overview:
- Parametrised, pipelined SIMD shifter. Successor to the fixed 16-bit, shift-by-one lane shifter.
- Treats a WIDTH-bit word as 1, 2 or 4 independent lanes.
- Applies a multi-bit shift or rotate to every lane: logical left, logical right, arithmetic right or rotate left.
- Sits between the SIMD register-read stage and writeback. Uses valid/ready handshakes on both sides and a two-register pipeline with full-throughput backpressure.

Parameters:
- WIDTH, 16, datapath width; legal values 8, 16, 32, 64; lane width LW = WIDTH/lanes.
- AW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts request this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AW  shift amount.
- in_mode  in  2  lane mode: 00 = one WIDTH lane, 01 = two WIDTH/2 lanes, 10 = four WIDTH/4 lanes, 11 = reserved.
- in_op  in  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = ROL.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0.
- out_err  out  1  request used reserved mode.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where valid && ready. Data is sampled only on a transfer.
- Stage 1 (S1):
  - Registers in_data, the effective amount, in_mode and in_op, and sets s1_valid.
  - Effective amount = in_amt mod LW, i.e. the low log2(LW) bits of in_amt.
- Stage 2 (S2, the output register):
  - Loads the combinational lane-shift of the S1 contents.
  - Drives out_valid, out_data, out_zero and out_err.
- Latency: a request accepted on edge k appears on out_valid/out_data after edge k+1. Minimum two edges from in_valid to consumable result.
- Throughput: one result per cycle while out_ready is held high.
- Advance rules:
  - S2 loads when s1_valid && (!out_valid || out_ready).
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free; combinational, with no combinational path from in_valid.
  - S1 clears when it hands off to S2 and no new request is accepted in the same edge.
- Simultaneous accept and hand-off: S1 reloads with the new request in the same edge. No bubble, no loss, order preserved.
- Stall (out_ready low with out_valid high):
  - out_data, out_zero and out_err hold stable.
  - S1 holds its request. in_ready falls once S1 is full.
- Per-lane arithmetic: each lane is shifted independently and no bit crosses a lane boundary.
  - SLL: zero fill at the lane LSB.
  - SRL: zero fill at the lane MSB.
  - SRA: replicate the lane MSB.
  - ROL: bits leaving the lane MSB re-enter at the lane LSB.
  - Amount 0: data passes unchanged for every op.
- Reserved mode 11: processed as mode 00 (one full-width lane), with out_err = 1 for that result only.
- out_zero: computed from the S2 result and registered alongside it.
- Reset (rst_n low, asynchronous):
  - s1_valid = 0, out_valid = 0, out_data = 0, out_zero = 0, out_err = 0, all S1 data registers = 0.
  - in_ready = 1 while in reset and after release.
  - In-flight requests are discarded with no partial output.
- After reset release: the first edge with in_valid = 1 is accepted.

Test Plan:
- WIDTH=16, mode 00, SLL, amt 1, in_data 16'h8001 -> out_data 16'h0002, out_zero 0, out_valid two edges after accept.
- Mode 10, SRA, amt 1, in_data 16'h8F4C -> 16'hCF2E (sign fill per 4-bit lane, no cross-lane bits).
- Mode 01, ROL, amt 3, in_data 16'h81F0 -> 16'h0C87; then SLL amt 8 in mode 01 on 16'hFFFF -> amt wraps to 0, output 16'hFFFF.
- Mode 10, SRL, amt 5, 16'hFFFF -> effective amt 1, 16'h7777. Mode 11, SLL, amt 4, 16'h1234 -> 16'h2340 with out_err 1; next normal request -> out_err 0.
- Backpressure:
  - Stimulus: stream requests A, B, C back-to-back (SLL amt 0, data 1, 2, 3); hold out_ready low for 4 cycles, then release.
  - Required: out_data holds 1 while stalled; in_ready drops after B is accepted; C accepted only after release; outputs are 1, 2, 3 in order with no duplicates.
- Reset mid-stream:
  - Stimulus: pull rst_n low asynchronously (mid-cycle) while S1 and S2 are both valid.
  - Required: out_valid 0 and out_data 0 immediately without waiting for a clock edge; after release, in_ready 1 and no stale result ever emerges.

Source files
------------

// File: rtl/simd_shifter_pipe_if.sv
// Request/result bus of the SIMD shifter: valid/ready request side feeding
// the pipeline, valid/ready result side toward writeback.
interface simd_shifter_pipe_if #(
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AW-1:0]    in_amt;
   logic [1:0]       in_mode;
   logic [1:0]       in_op;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic             out_err;

   // Requester / result consumer side.
   modport master (
      output in_valid, in_data, in_amt, in_mode, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_zero, out_err
   );

   // Shifter side.
   modport slave (
      input  in_valid, in_data, in_amt, in_mode, in_op, out_ready,
      output in_ready, out_valid, out_data, out_zero, out_err
   );
endinterface

// File: rtl/simd_shifter_pipe.sv
// Two-register pipelined SIMD shifter: 1, 2 or 4 independent lanes, each
// shifted or rotated by a per-request amount, with full-throughput backpressure.
module simd_shifter_pipe #(
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   simd_shifter_pipe_if.slave   bus
);

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      MODE_X1  = 2'b00,
      MODE_X2  = 2'b01,
      MODE_X4  = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic [AW-1:0]    s1_amt;
   mode_e            s1_mode;
   op_e              s1_op;

   logic             s2_free;
   logic             s2_load;
   logic             accept;
   logic [AW-1:0]    amt_mask;
   logic [WIDTH-1:0] shift_res;

   // ---------------------------------------------------------------------
   // Handshake: in_ready depends only on registered state and out_ready.
   // ---------------------------------------------------------------------
   assign s2_free      = !bus.out_valid || bus.out_ready;
   assign s2_load      = s1_valid && s2_free;
   assign bus.in_ready = !s1_valid || s2_free;
   assign accept       = bus.in_valid && bus.in_ready;

   // Shift amount is reduced modulo the lane width of the requested mode;
   // the reserved mode behaves as one full-width lane.
   always_comb begin
      case (mode_e'(bus.in_mode))
         MODE_X2: amt_mask = AW'(WIDTH / 2 - 1);
         MODE_X4: amt_mask = AW'(WIDTH / 4 - 1);
         default: amt_mask = AW'(WIDTH - 1);
      endcase
   end

   // ---------------------------------------------------------------------
   // Stage 1: request register.
   // ---------------------------------------------------------------------
   // NOTE: sequential state is written with <= only, so every register in
   // this block samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_amt   <= '0;
         s1_mode  <= MODE_X1;
         s1_op    <= OP_SLL;
      end else if (accept) begin
         // Covers the simultaneous hand-off case: S1 reloads, no bubble.
         s1_valid <= 1'b1;
         s1_data  <= bus.in_data;
         s1_amt   <= bus.in_amt & amt_mask;
         s1_mode  <= mode_e'(bus.in_mode);
         s1_op    <= op_e'(bus.in_op);
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Lane engines: one per lane count; no bit ever crosses a lane boundary.
   // ---------------------------------------------------------------------
   for (genvar g = 0; g < 3; g++) begin : gen_lane
      localparam int LW = WIDTH >> g;
      localparam int NL = 1 << g;

      logic [WIDTH-1:0] res;

      always_comb begin : p_lane
         logic [LW-1:0] v;
         // NOTE: every combinational output gets a default first so no path
         // through the loop or case can leave it unassigned (no latch).
         res = '0;
         v   = '0;
         for (int l = 0; l < NL; l++) begin
            v = s1_data[l*LW +: LW];
            case (s1_op)
               OP_SLL:  res[l*LW +: LW] = v << s1_amt;
               OP_SRL:  res[l*LW +: LW] = v >> s1_amt;
               OP_SRA:  res[l*LW +: LW] = LW'($signed(v) >>> s1_amt);
               default: res[l*LW +: LW] = (v << s1_amt) | (v >> (LW - int'(s1_amt)));
            endcase
         end
      end
   end

   always_comb begin
      case (s1_mode)
         MODE_X2: shift_res = gen_lane[1].res;
         MODE_X4: shift_res = gen_lane[2].res;
         default: shift_res = gen_lane[0].res;
      endcase
   end

   // ---------------------------------------------------------------------
   // Stage 2: output register; holds stable while the consumer stalls.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_zero  <= 1'b0;
         bus.out_err   <= 1'b0;
      end else if (s2_load) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= shift_res;
         bus.out_zero  <= (shift_res == '0);
         bus.out_err   <= (s1_mode == MODE_RSV);
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_simd_shifter_pipe.sv
// Scoreboard bench for simd_shifter_pipe at WIDTH=16: directed vectors,
// backpressure, asynchronous reset mid-stream and randomized traffic.
module tb_simd_shifter_pipe;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] data;
      logic         err;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   rand_done = 0;
   exp_t sb[$];

   simd_shifter_pipe_if #(.WIDTH(W)) bus ();

   simd_shifter_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Lane arithmetic from first principles: divide/multiply and bit-at-a-time
   // sign fill or rotation on each lane value taken as a plain integer.
   function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input int amt,
                                               input int mode, input int op);
      int     lanes = (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
      int     lw    = W / lanes;
      int     a     = amt % lw;
      int     full  = 1 << lw;
      int     half  = full / 2;
      int     v;
      longint acc   = 0;
      for (int l = 0; l < lanes; l++) begin
         v = (int'(d) >> (l * lw)) % full;
         case (op)
            0: v = (v * (1 << a)) % full;
            1: v = v / (1 << a);
            2: repeat (a) v = v / 2 + ((v >= half) ? half : 0);
            default: repeat (a) v = (v * 2) % full + ((v >= half) ? 1 : 0);
         endcase
         acc = acc + longint'(v) * (longint'(1) << (l * lw));
      end
      return W'(acc);
   endfunction

   // Presents one request, waits (bounded) for in_ready, records the expected
   // result at the accepting edge and returns just after that edge.
   task automatic send(input logic [W-1:0] d, input logic [3:0] a, input logic [1:0] m,
                       input logic [1:0] o, input logic [W-1:0] exp_d);
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_amt   = a;
      bus.in_mode  = m;
      bus.in_op    = o;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("in_ready_within_budget", bus.in_ready, 1'b1);
      if (!bus.in_ready) begin
         bus.in_valid = 1'b0;
         return;
      end
      sb.push_back('{data: exp_d, err: (m == 2'b11)});
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int i = 0;
      while (sb.size() != 0 && i < 200) begin
         @(posedge clk);
         #1;
         i++;
      end
      check("scoreboard_drained", sb.size(), 0);
   endtask

   // Monitor: every consumed result is compared with the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         check("result_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_zero", bus.out_zero, e.data == '0);
            check("out_err",  bus.out_err,  e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.in_mode   = '0;
      bus.in_op     = '0;
      bus.out_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_data",  bus.out_data,  16'h0000);
      check("rst_out_zero",  bus.out_zero,  1'b0);
      check("rst_out_err",   bus.out_err,   1'b0);
      check("rst_in_ready",  bus.in_ready,  1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      check("post_rst_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Latency: result visible after the edge following acceptance.
      send(16'h8001, 4'd1, 2'b00, 2'b00, 16'h0002);
      check("lat_not_yet_valid", bus.out_valid, 1'b0);
      @(posedge clk);
      #1 check("lat_valid_next_edge", bus.out_valid, 1'b1);

      // Directed lane vectors, streamed back to back.
      send(16'h8F4C, 4'd1, 2'b10, 2'b10, 16'hCF2E);
      send(16'h81F0, 4'd3, 2'b01, 2'b11, 16'h0C87);
      send(16'hFFFF, 4'd8, 2'b01, 2'b00, 16'hFFFF);
      send(16'hFFFF, 4'd5, 2'b10, 2'b01, 16'h7777);
      send(16'h1234, 4'd4, 2'b11, 2'b00, 16'h2340);
      send(16'h00F0, 4'd4, 2'b00, 2'b01, 16'h000F);
      send(16'h8000, 4'd1, 2'b00, 2'b00, 16'h0000);
      send(16'h5A3C, 4'd0, 2'b10, 2'b11, 16'h5A3C);
      drain();

      // Backpressure: A and B fill the pipe, C must wait for the release.
      bus.out_ready = 1'b0;
      send(16'h0001, 4'd0, 2'b00, 2'b00, 16'h0001);
      send(16'h0002, 4'd0, 2'b00, 2'b00, 16'h0002);
      check("bp_in_ready_drop", bus.in_ready, 1'b0);
      fork
         send(16'h0003, 4'd0, 2'b00, 2'b00, 16'h0003);
         begin
            repeat (4) begin
               @(negedge clk);
               check("bp_hold_valid", bus.out_valid, 1'b1);
               check("bp_hold_data",  bus.out_data,  16'h0001);
               check("bp_in_ready",   bus.in_ready,  1'b0);
            end
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain();

      // Asynchronous reset with both stages full.
      bus.out_ready = 1'b0;
      send(16'hAAAA, 4'd0, 2'b00, 2'b00, 16'hAAAA);
      send(16'h5555, 4'd0, 2'b00, 2'b00, 16'h5555);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      check("arst_out_valid", bus.out_valid, 1'b0);
      check("arst_out_data",  bus.out_data,  16'h0000);
      check("arst_in_ready",  bus.in_ready,  1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      check("arst_release_in_ready", bus.in_ready, 1'b1);
      repeat (4) begin
         @(negedge clk);
         check("arst_no_stale", bus.out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      send(16'h0F0F, 4'd4, 2'b00, 2'b11, 16'hF0F0);
      drain();

      // Randomized traffic with random consumer stalls.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [W-1:0] d;
               logic [3:0]   a;
               logic [1:0]   m;
               logic [1:0]   o;
               d = W'($urandom);
               if ($urandom_range(0, 7) == 0) d = '0;
               a = 4'($urandom_range(0, 15));
               m = 2'($urandom_range(0, 3));
               o = 2'($urandom_range(0, 3));
               send(d, a, m, o, ref_model(d, int'(a), int'(m), int'(o)));
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
